result_uart_tx: RTL and testbench

Reports the solver's final answer off-chip. On a one-cycle Start pulse it latches the result and error flag, converts the binary result to decimal ASCII by iterative double-dabble, strips leading zeros, and transmits the digits then CR LF over a UART 8N1 line. If the error flag is set, it transmits "ERR" CR LF instead. It sits in Top between the solver's Done/Error/result outputs and the board TX pin, and is the transmit end matched to the bench-side result receiver.

---
 rtl/result_tx_pkg.sv | 26 ++
 rtl/result_uart_tx_if.sv | 23 ++
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/result_uart_tx.sv | 122 ++++++++++++
 tb/tb_result_uart_tx.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// States, ASCII codes, framing and digit-count helper.
package result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SCAN,
    SEND,
    FINISH
  } state_t;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_E    = 8'h45;
  localparam logic [7:0] CHAR_R    = 8'h52;

  localparam int FRAME_BITS = 10;

  // ceil(width * log10(2)) in integer arithmetic
  function automatic int num_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Request/status bundle between the solver and the result transmitter.
// The solver side is master, the transmitter is slave.
interface result_uart_tx_if #(
  parameter int RESULT_WIDTH = 64
);

  logic                    Start;
  logic [RESULT_WIDTH-1:0] Result;
  logic                    IsError;
  logic                    Busy;
  logic                    Done;

  modport master (
    output Start, Result, IsError,
    input  Busy, Done
  );

  modport slave (
    input  Start, Result, IsError,
    output Busy, Done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with gapless chaining.
// Ready rises on the last stop-bit cycle so the next start bit follows at once.
module uart_tx_byte
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2170
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Valid,
  input  logic [7:0] Data,
  output logic       Ready,
  output logic       TxD
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

  logic          active;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [TW-1:0] timer;
  logic          last_cycle;

  assign last_cycle = active && bit_idx == STOP_IDX && timer == LAST;
  assign Ready = !active || last_cycle;

  // Load a frame on handshake, otherwise step bit timer and bit index
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      active  <= 1'b0;
      frame   <= '0;
      bit_idx <= '0;
      timer   <= '0;
      TxD     <= 1'b1;
    end else if (Valid && Ready) begin
      active  <= 1'b1;
      frame   <= {1'b1, Data, 1'b0};
      bit_idx <= '0;
      timer   <= '0;
      TxD     <= 1'b0;
    end else if (active) begin
      if (timer == LAST) begin
        timer <= '0;
        if (bit_idx == STOP_IDX) begin
          active <= 1'b0;
          TxD    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          TxD     <= frame[bit_idx + 4'd1];
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Sends the solver result as decimal ASCII + CR LF, or "ERR" CR LF.
// Binary to BCD via one double-dabble step per cycle.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int RESULT_WIDTH = 64,
  parameter int CLKS_PER_BIT = 2170
) (
  input  logic                 Clk,
  input  logic                 Rst,
  result_uart_tx_if.slave      bus,
  output logic                 TxD
);

  localparam int NUM_DIGITS = num_digits(RESULT_WIDTH);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS + 2);
  localparam int CW = $clog2(RESULT_WIDTH);

  state_t                  state, state_next;
  logic [RESULT_WIDTH-1:0] bin;
  logic [BW-1:0]           bcd, bcd_adj;
  logic                    err;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx, ndig, msd_count, total, dig_pos;
  logic [3:0]              digit;
  logic                    accept, tx_valid, tx_ready;
  logic [7:0]              tx_data;

  assign accept = (state == IDLE || state == FINISH) && bus.Start;
  assign total = ndig + IW'(2);
  assign bus.Busy = state == CONVERT || state == SCAN || state == SEND;
  assign bus.Done = state == FINISH;

  // Add-3 correction on every BCD digit above 4 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digit count from the most significant nonzero digit, minimum one
  always_comb begin
    msd_count = IW'(1);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd_count = IW'(i + 1);
    end
  end

  // Character for the current message position
  always_comb begin
    dig_pos = ndig - idx - IW'(1);
    digit   = 4'(bcd >> {dig_pos, 2'b00});
    tx_data = CHAR_ZERO | {4'd0, digit};
    if (idx == ndig) tx_data = CHAR_CR;
    else if (idx == ndig + IW'(1)) tx_data = CHAR_LF;
    else if (err) tx_data = (idx == '0) ? CHAR_E : CHAR_R;
  end

  // Sequencer state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and byte request
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    unique case (state)
      IDLE, FINISH: begin
        state_next = IDLE;
        if (bus.Start) state_next = bus.IsError ? SCAN : CONVERT;
      end
      CONVERT: if (cnt == CW'(RESULT_WIDTH - 1)) state_next = SCAN;
      SCAN:    state_next = SEND;
      SEND: begin
        tx_valid = idx < total;
        if (idx == total && tx_ready) state_next = FINISH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latches, conversion shift register and message index
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bin  <= '0;
      bcd  <= '0;
      err  <= 1'b0;
      cnt  <= '0;
      idx  <= '0;
      ndig <= '0;
    end else if (accept) begin
      bin <= bus.Result;
      err <= bus.IsError;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
    end else if (state == CONVERT) begin
      {bcd, bin} <= {bcd_adj, bin} << 1;
      cnt <= cnt + 1'b1;
    end else if (state == SCAN) begin
      ndig <= err ? IW'(3) : msd_count;
    end else if (state == SEND && tx_valid && tx_ready) begin
      idx <= idx + 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clk  (Clk),
    .Rst  (Rst),
    .Valid(tx_valid),
    .Data (tx_data),
    .Ready(tx_ready),
    .TxD  (TxD)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx at 4 clocks per bit.
// Decodes TxD cycle by cycle against hand-written messages.
module tb_result_uart_tx;

  localparam int RW  = 64;
  localparam int CPB = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic TxD;

  result_uart_tx_if #(.RESULT_WIDTH(RW)) bus ();

  always #5 Clk = ~Clk;

  result_uart_tx #(
    .RESULT_WIDTH(RW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus),
    .TxD(TxD)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [63:0] r, input logic e);
    bus.Start   = 1'b1;
    bus.Result  = r;
    bus.IsError = e;
  endtask

  // Called with Start already raised at a negedge.
  task automatic expect_msg(input string tag, input string exp,
                            input int lat, input int poke,
                            input bit chain, input logic [63:0] chain_r);
    int k;
    bit bad_frame, bad_busy, bad_done;
    logic [39:0] w;
    logic [9:0] fr;
    logic [7:0] b;
    bad_frame = 0;
    bad_busy  = 0;
    bad_done  = 0;
    @(negedge Clk);
    bus.Start = 1'b0;
    k = 0;
    while (TxD === 1'b1 && k < 300) begin
      if (bus.Busy !== 1'b1) bad_busy = 1;
      if (bus.Done !== 1'b0) bad_done = 1;
      @(negedge Clk);
      k++;
    end
    check({tag, "/latency"}, 64'(k), 64'(lat));
    if (k >= 300) return;
    for (int f = 0; f < exp.len(); f++) begin
      for (int c = 0; c < 40; c++) begin
        w[c] = TxD;
        if (bus.Busy !== 1'b1) bad_busy = 1;
        if (bus.Done !== 1'b0) bad_done = 1;
        bus.Start = (f * 40 + c == poke);
        if (bus.Start) bus.Result = 64'd9876;
        @(negedge Clk);
      end
      for (int j = 0; j < 10; j++) begin
        fr[j] = w[4*j+1];
        for (int q = 0; q < 4; q++)
          if (w[4*j+q] !== fr[j]) bad_frame = 1;
      end
      if (fr[0] !== 1'b0 || fr[9] !== 1'b1) bad_frame = 1;
      b = fr[8:1];
      check($sformatf("%s/byte%0d", tag, f), 64'(b), 64'(exp[f]));
    end
    check({tag, "/done"}, 64'(bus.Done), 64'd1);
    check({tag, "/busy_end"}, 64'(bus.Busy), 64'd0);
    check({tag, "/framing"}, 64'(bad_frame), 64'd0);
    check({tag, "/busy_hold"}, 64'(bad_busy), 64'd0);
    check({tag, "/early_done"}, 64'(bad_done), 64'd0);
    if (chain) begin
      pulse(chain_r, 1'b0);
    end else begin
      @(negedge Clk);
      check({tag, "/done_once"}, 64'(bus.Done), 64'd0);
    end
  endtask

  initial begin
    int k;
    bit bad;
    bus.Start   = 1'b0;
    bus.Result  = '0;
    bus.IsError = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst/txd", 64'(TxD), 64'd1);
    check("rst/busy", 64'(bus.Busy), 64'd0);
    check("rst/done", 64'(bus.Done), 64'd0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    pulse(64'd0, 1'b0);
    expect_msg("zero", "0\r\n", 66, -1, 1'b0, '0);

    pulse(64'd1234, 1'b0);
    expect_msg("n1234", "1234\r\n", 66, -1, 1'b0, '0);

    pulse(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    expect_msg("max", "18446744073709551615\r\n", 66, -1, 1'b0, '0);

    pulse(64'd999, 1'b1);
    expect_msg("err", "ERR\r\n", 2, -1, 1'b0, '0);

    pulse(64'd42, 1'b0);
    expect_msg("poke", "42\r\n", 66, 50, 1'b1, 64'd305);
    expect_msg("chain", "305\r\n", 66, -1, 1'b0, '0);

    repeat (3) @(negedge Clk);
    pulse(64'd1234, 1'b0);
    @(negedge Clk);
    bus.Start = 1'b0;
    k = 0;
    while (TxD === 1'b1 && k < 300) begin
      @(negedge Clk);
      k++;
    end
    check("rstmid/latency", 64'(k), 64'd66);
    repeat (53) @(negedge Clk);
    check("rstmid/bit_low", 64'(TxD), 64'd0);
    #2;
    Rst = 1'b1;
    #1;
    check("rstmid/txd", 64'(TxD), 64'd1);
    check("rstmid/busy", 64'(bus.Busy), 64'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.Done !== 1'b0 || TxD !== 1'b1 || bus.Busy !== 1'b0) bad = 1;
      @(negedge Clk);
    end
    check("rstmid/quiet", 64'(bad), 64'd0);

    pulse(64'd7, 1'b0);
    expect_msg("after_rst", "7\r\n", 66, -1, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
